// File: rtl/mic_stream_ctrl.sv
// mic_stream_ctrl
// Recording controller for the microphone stream. Host commands start and stop
// recording. Each outbound link slot is given to one of two requesters: the
// microphone and the status source. The mic may win at most MIC_BURST slots in
// a row while status is waiting. The block also flags a start timeout and
// stream underrun.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid, cmd_code : host command strobe and code
//   record_start/stop   : one-cycle pulses to the Microphone block
//   mic_data(_valid)    : mic word and level-valid; mic_data_retrieved acks it
//   status_data(_valid) : status word and level-valid; status_retrieved acks it
//   tx_slot             : outbound slot pulse
//   tx_valid/data/kind  : granted word (kind 1 = mic, 2 = status)
//   rec_active          : high in STARTING or ACTIVE
//   err_start, underrun : sticky error flags, cleared by an accepted start
module mic_stream_ctrl #(
   parameter logic [7:0] CMD_START     = 8'h01,
   parameter logic [7:0] CMD_STOP      = 8'h02,
   parameter int         START_TIMEOUT = 1024,
   parameter int         STOP_HOLD     = 16,
   parameter int         MIC_BURST     = 4,
   parameter int         GAP_LIMIT     = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_code,
   output logic        record_start,
   output logic        record_stop,
   input  logic [31:0] mic_data,
   input  logic        mic_data_valid,
   output logic        mic_data_retrieved,
   input  logic [31:0] status_data,
   input  logic        status_valid,
   output logic        status_retrieved,
   input  logic        tx_slot,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   output logic [1:0]  tx_kind,
   output logic        rec_active,
   output logic        err_start,
   output logic        underrun
);

   localparam int SW = $clog2(START_TIMEOUT + 1);
   localparam int HW = $clog2(STOP_HOLD + 1);
   localparam int GW = $clog2(GAP_LIMIT + 1);
   localparam int BW = $clog2(MIC_BURST + 1);
   localparam logic [SW-1:0] START_LAST = SW'(START_TIMEOUT - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(STOP_HOLD - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_LIMIT - 1);
   localparam logic [BW-1:0] BURST_MAX  = BW'(MIC_BURST);
   localparam logic [1:0]    KIND_MIC    = 2'd1;
   localparam logic [1:0]    KIND_STATUS = 2'd2;

   typedef enum logic [1:0] {IDLE, STARTING, ACTIVE, STOPPING} state_t;

   state_t          state_reg, state_next;
   logic [SW-1:0]   start_cnt_reg;
   logic [HW-1:0]   hold_cnt_reg;
   logic [GW-1:0]   gap_cnt_reg;
   logic [BW-1:0]   burst_cnt_reg;
   logic            holdoff_tail_reg;
   logic            boot_reg;
   logic            tx_valid_reg, mic_ret_reg, stat_ret_reg;
   logic [31:0]     tx_data_reg;
   logic [1:0]      tx_kind_reg;
   logic            record_start_reg, record_stop_reg;
   logic            err_start_reg, underrun_reg;

   logic cmd_start, cmd_stop, recording;
   logic do_start, do_stop, timeout;
   logic mic_elig, arb_open, grant_mic, grant_status, gap_hit;

   assign cmd_start = cmd_valid && (cmd_code == CMD_START);
   assign cmd_stop  = cmd_valid && (cmd_code == CMD_STOP);
   assign recording = (state_reg == STARTING) || (state_reg == ACTIVE);

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      do_start   = 1'b0;
      do_stop    = 1'b0;
      timeout    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_start) begin
               state_next = STARTING;
               do_start   = 1'b1;
            end
         end
         STARTING: begin
            if (cmd_stop) begin
               state_next = STOPPING;
               do_stop    = 1'b1;
            end else if (mic_data_valid) begin
               state_next = ACTIVE;
            end else if (start_cnt_reg == START_LAST) begin
               state_next = STOPPING;
               do_stop    = 1'b1;
               timeout    = 1'b1;
            end
         end
         ACTIVE: begin
            if (cmd_stop) begin
               state_next = STOPPING;
               do_stop    = 1'b1;
            end
         end
         STOPPING: begin
            if (hold_cnt_reg == HOLD_LAST) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // A mic word still valid while recording is being torn down is not taken.
      mic_elig     = mic_data_valid && recording && !do_stop;
      // Holdoff covers the tx_valid cycle and the one after it.
      arb_open     = tx_slot && !tx_valid_reg && !holdoff_tail_reg;
      grant_status = arb_open && status_valid && ((burst_cnt_reg == BURST_MAX) || !mic_elig);
      grant_mic    = arb_open && !grant_status && mic_elig;
      gap_hit      = (state_reg == ACTIVE) && !grant_mic && (gap_cnt_reg == GAP_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         start_cnt_reg    <= '0;
         hold_cnt_reg     <= '0;
         gap_cnt_reg      <= '0;
         burst_cnt_reg    <= '0;
         holdoff_tail_reg <= 1'b0;
         boot_reg         <= 1'b1;
         tx_valid_reg     <= 1'b0;
         mic_ret_reg      <= 1'b0;
         stat_ret_reg     <= 1'b0;
         tx_data_reg      <= '0;
         tx_kind_reg      <= '0;
         record_start_reg <= 1'b0;
         record_stop_reg  <= 1'b0;
         err_start_reg    <= 1'b0;
         underrun_reg     <= 1'b0;
      end else begin
         // The first cycle out of reset forces the Microphone block idle.
         boot_reg         <= 1'b0;
         record_start_reg <= do_start;
         record_stop_reg  <= do_stop || boot_reg;

         start_cnt_reg <= (state_reg == STARTING) ? start_cnt_reg + 1'b1 : '0;
         hold_cnt_reg  <= (state_reg == STOPPING) ? hold_cnt_reg + 1'b1 : '0;

         if (state_reg != ACTIVE)  gap_cnt_reg <= '0;
         else if (grant_mic || gap_hit) gap_cnt_reg <= '0;
         else                      gap_cnt_reg <= gap_cnt_reg + 1'b1;

         if (do_start) begin
            err_start_reg <= 1'b0;
            underrun_reg  <= 1'b0;
         end else begin
            if (timeout) err_start_reg <= 1'b1;
            if (gap_hit) underrun_reg  <= 1'b1;
         end

         tx_valid_reg     <= grant_mic || grant_status;
         mic_ret_reg      <= grant_mic;
         stat_ret_reg     <= grant_status;
         holdoff_tail_reg <= tx_valid_reg;
         if (grant_status) begin
            tx_data_reg <= status_data;
            tx_kind_reg <= KIND_STATUS;
         end else if (grant_mic) begin
            tx_data_reg <= mic_data;
            tx_kind_reg <= KIND_MIC;
         end

         // Burst only accumulates while status is actually waiting.
         if (grant_mic) begin
            if (!status_valid)                  burst_cnt_reg <= '0;
            else if (burst_cnt_reg != BURST_MAX) burst_cnt_reg <= burst_cnt_reg + 1'b1;
         end else if (grant_status) begin
            burst_cnt_reg <= '0;
         end
      end
   end

   assign record_start       = record_start_reg;
   assign record_stop        = record_stop_reg;
   assign mic_data_retrieved = mic_ret_reg;
   assign status_retrieved   = stat_ret_reg;
   assign tx_valid           = tx_valid_reg;
   assign tx_data            = tx_data_reg;
   assign tx_kind            = tx_kind_reg;
   assign rec_active         = recording;
   assign err_start          = err_start_reg;
   assign underrun           = underrun_reg;

endmodule

// File: tb/tb_mic_stream_ctrl.sv
// Testbench for mic_stream_ctrl: a timestamp-based reference model predicts
// every output each cycle; scenario tasks add targeted checks.
module tb_mic_stream_ctrl;

   localparam logic [7:0] C_START = 8'h01;
   localparam logic [7:0] C_STOP  = 8'h02;
   localparam int START_TIMEOUT = 1024;
   localparam int STOP_HOLD     = 16;
   localparam int MIC_BURST     = 4;
   localparam int GAP_LIMIT     = 4096;
   localparam int M_IDLE = 0, M_STARTING = 1, M_ACTIVE = 2, M_STOPPING = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [7:0]  cmd_code;
   logic        record_start, record_stop;
   logic [31:0] mic_data;
   logic        mic_data_valid, mic_data_retrieved;
   logic [31:0] status_data;
   logic        status_valid, status_retrieved;
   logic        tx_slot, tx_valid;
   logic [31:0] tx_data;
   logic [1:0]  tx_kind;
   logic        rec_active, err_start, underrun;

   int n_checks = 0;
   int n_fail   = 0;

   mic_stream_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
      .record_start(record_start), .record_stop(record_stop),
      .mic_data(mic_data), .mic_data_valid(mic_data_valid),
      .mic_data_retrieved(mic_data_retrieved),
      .status_data(status_data), .status_valid(status_valid),
      .status_retrieved(status_retrieved), .tx_slot(tx_slot),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_kind(tx_kind),
      .rec_active(rec_active), .err_start(err_start), .underrun(underrun)
   );

   always #5 clk = ~clk;

   // Reference model: mode plus cycle timestamps of entry, last grant and last
   // mic service.
   longint cyc = 0;
   int     m_mode = M_IDLE;
   longint m_entry = 0, m_gap_ref = 0, m_last_grant = -100;
   int     m_mic_run = 0;
   bit     m_boot = 1'b1;
   logic   e_rstart = 0, e_rstop = 0, e_txv = 0, e_mret = 0, e_sret = 0, e_err = 0, e_und = 0;
   logic [1:0]  e_kind = 0;
   logic [31:0] e_data = 0;

   task automatic model_step();
      bit is_start, is_stop, recording, stop_now, tmo, mic_ok, slot_ok, g_st, g_mic, gap_hit;
      longint elapsed;
      if (rst) begin
         m_mode = M_IDLE; m_boot = 1'b1; m_mic_run = 0; m_last_grant = -100;
         {e_rstart, e_rstop, e_txv, e_mret, e_sret, e_err, e_und} = '0;
         e_kind = '0; e_data = '0;
      end else begin
         is_start  = cmd_valid && cmd_code == C_START;
         is_stop   = cmd_valid && cmd_code == C_STOP;
         recording = (m_mode == M_STARTING) || (m_mode == M_ACTIVE);
         elapsed   = cyc - m_entry + 1;
         stop_now  = recording && is_stop;
         tmo       = (m_mode == M_STARTING) && !stop_now && !mic_data_valid && elapsed == START_TIMEOUT;
         mic_ok    = mic_data_valid && recording && !stop_now;
         slot_ok   = tx_slot && (cyc >= m_last_grant + 3);
         g_st      = slot_ok && status_valid && (m_mic_run == MIC_BURST || !mic_ok);
         g_mic     = slot_ok && !g_st && mic_ok;
         gap_hit   = (m_mode == M_ACTIVE) && !g_mic && (cyc - m_gap_ref + 1 == GAP_LIMIT);

         e_txv = g_st || g_mic; e_mret = g_mic; e_sret = g_st;
         if (g_st)  begin e_data = status_data; e_kind = 2'd2; end
         if (g_mic) begin e_data = mic_data;    e_kind = 2'd1; end
         if (g_st || g_mic) m_last_grant = cyc;
         if (g_mic) m_mic_run = status_valid ? ((m_mic_run < MIC_BURST) ? m_mic_run + 1 : MIC_BURST) : 0;
         if (g_st)  m_mic_run = 0;
         if (g_mic || gap_hit) m_gap_ref = cyc + 1;

         e_rstart = (m_mode == M_IDLE) && is_start;
         e_rstop  = stop_now || tmo || m_boot;
         m_boot   = 1'b0;
         if (e_rstart) begin e_err = 0; e_und = 0; end
         if (tmo) e_err = 1;
         if (gap_hit) e_und = 1;

         case (m_mode)
            M_IDLE:     if (is_start) begin m_mode = M_STARTING; m_entry = cyc + 1; end
            M_STARTING: if (stop_now || tmo) begin m_mode = M_STOPPING; m_entry = cyc + 1; end
                        else if (mic_data_valid) begin m_mode = M_ACTIVE; m_entry = cyc + 1; m_gap_ref = cyc + 1; end
            M_ACTIVE:   if (stop_now) begin m_mode = M_STOPPING; m_entry = cyc + 1; end
            default:    if (elapsed == STOP_HOLD) m_mode = M_IDLE;
         endcase
      end
      cyc++;
   endtask

   function automatic logic [41:0] obs_vec();
      return {record_start, record_stop, tx_valid, tx_kind, mic_data_retrieved,
              status_retrieved, rec_active, err_start, underrun, tx_data};
   endfunction

   function automatic logic [41:0] exp_vec();
      logic ra;
      ra = (m_mode == M_STARTING) || (m_mode == M_ACTIVE);
      return {e_rstart, e_rstop, e_txv, e_kind, e_mret, e_sret, ra, e_err, e_und, e_data};
   endfunction

   // Inputs change on the falling edge; DUT and model both sample at the rising edge.
   task automatic cycle();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic quiet_inputs();
      cmd_valid = 0; cmd_code = 8'h00; tx_slot = 0;
      mic_data_valid = 0; status_valid = 0;
      mic_data = $urandom; status_data = $urandom;
   endtask

   task automatic settle(input int n);
      cmd_valid = 0; tx_slot = 0;
      for (int i = 0; i < n; i++) begin
         cycle();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL settle_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic go_idle();
      quiet_inputs();
      cmd_valid = 1; cmd_code = C_STOP;
      cycle();
      cmd_valid = 0;
      settle(STOP_HOLD + 4);
   endtask

   task automatic test_reset();
      logic [41:0] want;
      rst = 1;
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'($urandom); cmd_code = 8'($urandom_range(1, 2));
         tx_slot = 1'($urandom); mic_data_valid = 1; status_valid = 1;
         mic_data = $urandom; status_data = $urandom;
         cycle();
         if (i > 0) begin
            n_checks++;
            if (obs_vec() !== 42'd0) begin
               n_fail++;
               $display("FAIL reset_outputs got=%h want=0", obs_vec());
            end
         end
      end
      rst = 0;
      quiet_inputs();
      cycle();
      want = '0; want[40] = 1'b1;
      n_checks++;
      if (obs_vec() !== want) begin
         n_fail++;
         $display("FAIL reset_release_stop got=%h want=%h", obs_vec(), want);
      end
      cycle();
      n_checks++;
      if (record_stop !== 1'b0 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_stop_single got=%h want=%h", obs_vec(), exp_vec());
      end
      $display("reset: release pulse checked");
   endtask

   task automatic test_start_first_grant();
      int first_k = -1;
      quiet_inputs();
      cmd_valid = 1; cmd_code = C_START;
      cycle();
      cmd_valid = 0;
      n_checks++;
      if (record_start !== 1'b1) begin
         n_fail++;
         $display("FAIL start_pulse got=%b want=1", record_start);
      end
      for (int k = 1; k <= 200; k++) begin
         mic_data_valid = (k >= 101);
         mic_data = (k >= 101) ? 32'hFFFFFFFF : $urandom;
         tx_slot = (k % 8 == 0);
         cycle();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL start_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         if (tx_valid === 1'b1 && first_k < 0) begin
            first_k = k;
            n_checks++;
            if (tx_kind !== 2'd1 || tx_data !== 32'hFFFFFFFF || first_k != 104) begin
               n_fail++;
               $display("FAIL first_grant k=%0d kind=%0d data=%h want k=104 kind=1 data=ffffffff",
                        first_k, tx_kind, tx_data);
            end
         end
      end
      n_checks++;
      if (first_k < 0) begin
         n_fail++;
         $display("FAIL first_grant_timeout got=none want=grant");
      end
      $display("start: first grant at k=%0d kind=%0d data=%h", first_k, tx_kind, tx_data);
   endtask

   task automatic test_burst();
      int got[12];
      int ngot = 0, slots = 0;
      int want[12] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1, 1};
      mic_data_valid = 1; status_valid = 1;
      settle(3);
      for (int k = 0; k < 60; k++) begin
         tx_slot = (k % 4 == 0) && (slots < 12);
         if (tx_slot) slots++;
         mic_data = $urandom; status_data = $urandom;
         cycle();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL burst_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         if (tx_valid === 1'b1 && ngot < 12) begin
            got[ngot] = int'(tx_kind);
            ngot++;
         end
      end
      tx_slot = 0;
      n_checks++;
      if (ngot != 12) begin
         n_fail++;
         $display("FAIL burst_count got=%0d want=12", ngot);
      end
      for (int i = 0; i < ngot; i++) begin
         n_checks++;
         if (got[i] != want[i]) begin
            n_fail++;
            $display("FAIL burst_seq idx=%0d got=%0d want=%0d", i, got[i], want[i]);
         end
      end
      $display("burst: %0d grants checked", ngot);
   endtask

   task automatic test_back_to_back();
      int n_tx = 0, n_ret = 0, last_ret = -10;
      mic_data_valid = 1; status_valid = 0;
      settle(3);
      for (int k = 0; k < 30; k++) begin
         tx_slot = 1; mic_data = $urandom;
         cycle();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         if (tx_valid === 1'b1) n_tx++;
         if (mic_data_retrieved === 1'b1) begin
            n_ret++;
            n_checks++;
            if (k - last_ret < 3) begin
               n_fail++;
               $display("FAIL b2b_spacing got=%0d want>=3", k - last_ret);
            end
            last_ret = k;
         end
      end
      tx_slot = 0;
      n_checks++;
      if (n_tx != 10 || n_ret != 10) begin
         n_fail++;
         $display("FAIL b2b_count got=%0d/%0d want=10/10", n_tx, n_ret);
      end
      $display("back_to_back: %0d grants in 30 slots", n_tx);
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         rst = ($urandom_range(0, 499) == 0);
         cmd_valid = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 2))
            0:       cmd_code = C_START;
            1:       cmd_code = C_STOP;
            default: cmd_code = 8'($urandom);
         endcase
         mic_data_valid = ($urandom_range(0, 3) != 0);
         status_valid = 1'($urandom);
         tx_slot = 1'($urandom);
         mic_data = $urandom; status_data = $urandom;
         cycle();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
      end
      rst = 0;
      $display("random: 1500 cycles compared");
   endtask

   task automatic test_start_timeout();
      int err_k = -1;
      go_idle();
      cmd_valid = 1; cmd_code = C_START;
      cycle();
      for (int k = 1; k <= 1041; k++) begin
         cmd_valid = (k >= 1040); cmd_code = C_START;
         cycle();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL timeout_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         if (err_start === 1'b1 && err_k < 0) begin
            err_k = k;
            n_checks++;
            if (k != START_TIMEOUT || record_stop !== 1'b1) begin
               n_fail++;
               $display("FAIL timeout_point got=k%0d stop=%b want=k%0d stop=1", k, record_stop, START_TIMEOUT);
            end
         end
         if (k == 1040) begin
            n_checks++;
            if (record_start !== 1'b0) begin
               n_fail++;
               $display("FAIL stopping_ignores_start got=%b want=0", record_start);
            end
         end
      end
      cmd_valid = 0;
      n_checks++;
      if (record_start !== 1'b1 || err_start !== 1'b0 || err_k < 0) begin
         n_fail++;
         $display("FAIL restart_clears_err got=start%b err%b errk%0d want=start1 err0", record_start, err_start, err_k);
      end
      $display("timeout: err_start raised at k=%0d", err_k);
   endtask

   task automatic test_underrun();
      int und_k = -1;
      quiet_inputs();
      mic_data_valid = 1;
      cycle();
      mic_data_valid = 0;
      for (int k = 1; k <= GAP_LIMIT + 4; k++) begin
         cycle();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL underrun_model cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         if (underrun === 1'b1 && und_k < 0) und_k = k;
      end
      n_checks++;
      if (und_k != GAP_LIMIT) begin
         n_fail++;
         $display("FAIL underrun_point got=%0d want=%0d", und_k, GAP_LIMIT);
      end
      cmd_valid = 1; cmd_code = C_STOP;
      cycle();
      n_checks++;
      if (record_stop !== 1'b1 || rec_active !== 1'b0) begin
         n_fail++;
         $display("FAIL underrun_stop got=stop%b act%b want=stop1 act0", record_stop, rec_active);
      end
      cmd_code = C_START;
      cycle();
      cmd_valid = 0;
      n_checks++;
      if (record_start !== 1'b0 || underrun !== 1'b1 || rec_active !== 1'b0) begin
         n_fail++;
         $display("FAIL stopping_start_ignored got=start%b und%b act%b want=start0 und1 act0",
                  record_start, underrun, rec_active);
      end
      settle(STOP_HOLD + 4);
      $display("underrun: raised at k=%0d", und_k);
   endtask

   task automatic test_reset_midflight();
      quiet_inputs();
      cmd_valid = 1; cmd_code = C_START;
      cycle();
      cmd_valid = 0; mic_data_valid = 1;
      settle(4);
      tx_slot = 1; rst = 1;
      cycle();
      n_checks++;
      if (tx_valid !== 1'b0 || mic_data_retrieved !== 1'b0 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_midflight got=%h want=%h", obs_vec(), exp_vec());
      end
      rst = 0; tx_slot = 0; mic_data_valid = 0;
      cycle();
      n_checks++;
      if (record_stop !== 1'b1 || mic_data_retrieved !== 1'b0 || obs_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_midflight_release got=%h want=%h", obs_vec(), exp_vec());
      end
      $display("reset_midflight: in-flight grant dropped");
   endtask

   initial begin
      rst = 1;
      quiet_inputs();
      test_reset();
      test_start_first_grant();
      test_burst();
      test_back_to_back();
      test_random();
      test_start_timeout();
      test_underrun();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
